// File: rtl/gpio_apb_arb_pkg.sv
// gpio_apb_arb_pkg: FSM state type, default widths and port indices for gpio_apb_arb
package gpio_apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int SW = 0;
  localparam int LP = 1;
endpackage

// File: rtl/gpio_apb_rr_arb.sv
// gpio_apb_rr_arb: 2-way sw/lp grant, round-robin or lp fixed priority when GPIO_APB_ARB_LP_PRIO_EN is defined
module gpio_apb_rr_arb
  import gpio_apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);
`ifdef GPIO_APB_ARB_LP_PRIO_EN
  assign gnt[LP] = en && valid[LP];
  assign gnt[SW] = en && valid[SW] && !valid[LP];
`else
  logic last_lp;
  assign gnt[SW] = en && valid[SW] && (!valid[LP] || last_lp);
  assign gnt[LP] = en && valid[LP] && (!valid[SW] || !last_lp);
  always_ff @(posedge clk)
    if (rst) last_lp <= 1'b1;
    else if (|gnt) last_lp <= gnt[LP];
`endif
endmodule

// File: rtl/gpio_apb_arb.sv
// gpio_apb_arb: two-requester APB master for a GPIO slave; define GPIO_APB_ARB_LP_PRIO_EN for lp fixed priority
module gpio_apb_arb
  import gpio_apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              pclk,
  input  logic              p_reset,
  input  logic              sw_req_valid,
  output logic              sw_req_ready,
  input  logic              sw_req_write,
  input  logic [ADDR_W-1:0] sw_req_addr,
  input  logic [DATA_W-1:0] sw_req_wdata,
  output logic              sw_rsp_valid,
  input  logic              lp_req_valid,
  output logic              lp_req_ready,
  input  logic              lp_req_write,
  input  logic [ADDR_W-1:0] lp_req_addr,
  input  logic [DATA_W-1:0] lp_req_wdata,
  output logic              lp_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy
);
  state_t state, state_nx;
  logic [1:0] gnt;
  logic owner_lp;
  gpio_apb_rr_arb u_arb (
    .clk  (pclk),
    .rst  (p_reset),
    .en   (state == IDLE),
    .valid({lp_req_valid, sw_req_valid}),
    .gnt  (gnt)
  );
  assign sw_req_ready = gnt[SW];
  assign lp_req_ready = gnt[LP];
  always_comb state_nx = state == IDLE ? (|gnt ? SETUP : IDLE) : state == SETUP ? ACCESS : IDLE;
  always_ff @(posedge pclk)
    if (p_reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge pclk)
    if (p_reset) begin
      psel         <= 1'b0;
      penable      <= 1'b0;
      busy         <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      owner_lp     <= 1'b0;
      sw_rsp_valid <= 1'b0;
      lp_rsp_valid <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      psel         <= state_nx != IDLE;
      penable      <= state_nx == ACCESS;
      busy         <= state_nx != IDLE;
      sw_rsp_valid <= state == ACCESS && !owner_lp;
      lp_rsp_valid <= state == ACCESS && owner_lp;
      if (|gnt) begin
        pwrite   <= gnt[LP] ? lp_req_write : sw_req_write;
        paddr    <= gnt[LP] ? lp_req_addr : sw_req_addr;
        pwdata   <= gnt[LP] ? lp_req_wdata : sw_req_wdata;
        owner_lp <= gnt[LP];
      end
      if (state == ACCESS && !pwrite) rsp_rdata <= prdata;
    end
endmodule

// File: doc/gpio_apb_arb.md
GPIO_APB_ARB -- requirements
Module: gpio_apb_arb

Interface
REQ-001 Parameter ADDR_W, 6, APB address width to the GPIO slave.
REQ-002 Parameter DATA_W, 32, APB data width.
REQ-003 The block SHALL use one clock and one reset: reset is synchronous and active-high; ports pclk and p_reset.
REQ-004 pclk  input  1  APB clock; all state changes on rising edge.
REQ-005 p_reset  input  1  synchronous active-high reset.
REQ-006 sw_req_valid / lp_req_valid  input  1 each  software / low-power-controller request pending.
REQ-007 sw_req_ready / lp_req_ready  output  1 each  request accepted this cycle.
REQ-008 sw_req_write / lp_req_write  input  1 each  1 = write, 0 = read.
REQ-009 sw_req_addr / lp_req_addr  input  ADDR_W each  GPIO register address.
REQ-010 sw_req_wdata / lp_req_wdata  input  DATA_W each  write data.
REQ-011 sw_rsp_valid / lp_rsp_valid  output  1 each  one-cycle completion pulse, reads and writes.
REQ-012 rsp_rdata  output  DATA_W  read data, valid with either rsp_valid.
REQ-013 psel, penable, pwrite  output  1 each  APB master controls to GPIO slave.
REQ-014 paddr  output  ADDR_W;  pwdata  output  DATA_W;  prdata  input  DATA_W.
REQ-015 busy  output  1  high in SETUP or ACCESS.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS; IDLE->SETUP on accept, SETUP->ACCESS always, ACCESS->IDLE always.
REQ-017 In IDLE with at least one valid, req_ready SHALL be driven combinationally high for exactly one winner that cycle; ready is 0 in all other states.
REQ-018 On accept, write/addr/wdata and owner port SHALL be registered; paddr/pwrite/pwdata stay stable from SETUP through ACCESS.
REQ-019 SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1; IDLE: psel=0, penable=0.
REQ-020 prdata SHALL be sampled at the end of ACCESS into rsp_rdata; for writes rsp_rdata holds its previous value.
REQ-021 Latency: accept at cycle T -> psel at T+1, penable at T+2, owner rsp_valid=1 at T+3 for one cycle only.
REQ-022 Throughput: next accept no earlier than T+3 (the cycle rsp_valid is high); peak one transfer per 3 cycles.
REQ-023 Arbitration default: round-robin; when both valid, grant the port not granted last; single valid wins unconditionally.
REQ-024 A request dropped before ready SHALL NOT be accepted; no APB activity results.
REQ-025 All outputs except req_ready SHALL be registered.

Reset
REQ-026 On p_reset: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0 both, rsp_rdata=0, busy=0, last-grant=lp (sw wins first tie).
REQ-027 Reset mid-transfer SHALL abort: psel low the following cycle, no rsp_valid for the aborted transfer.

Configuration
REQ-028 Macro GPIO_APB_ARB_LP_PRIO_EN defined: lp port SHALL win every tie (fixed priority); last-grant register unused.
REQ-029 Macro undefined: round-robin per REQ-023.

Structure
REQ-030 Package gpio_apb_arb_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and port-index constants (SW=0, LP=1).
REQ-031 Sub-module gpio_apb_rr_arb SHALL implement the 2-way grant logic (including macro variant); FSM and APB drive stay in gpio_apb_arb.

Verification
REQ-032 sw write addr 0x04 data 0x0000_00FF at T -> psel T+1, penable T+2 with pwrite=1 paddr=0x04, sw_rsp_valid at T+3.
REQ-033 lp read addr 0x08 with slave prdata=0x0000_A5A5 -> lp_rsp_valid at T+3, rsp_rdata=0x0000_A5A5, sw_rsp_valid=0.
REQ-034 Both valid continuously for 4 transfers, macro off -> grants sw, lp, sw, lp; macro on -> lp, lp, lp, lp.
REQ-035 p_reset asserted during ACCESS -> next cycle psel=0, penable=0, no rsp_valid, busy=0.
REQ-036 sw_req_valid pulsed while busy then dropped -> no ready, no extra APB transfer.
